// File: rtl/datapath_core.sv
// datapath_core: register file, operand buses, ALU with iterative shift-add multiplier,
// registered status flags and a per-instruction FSM (IDLE -> EXEC -> [MUL] -> WB).
//
// Ports:
//   clk, highRst            clock; asynchronous active-high reset
//   sInstrValid/sInstrReady  instruction handshake (ready only in IDLE, low during reset)
//   sOpAlu, sSelA, sSelB,    operation, source/destination selects, immediate select
//   sSelC, sImmSel, sImm     and immediate value
//   sDone                    one-cycle pulse during write-back
//   sOverflow/sCarry/        flags of the last completed instruction
//   sNegative/sZero
//   sDbgSel/sDbgData         combinational debug read of the register file
module datapath_core #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned REGCOUNT  = 8,
    parameter int unsigned SELECTION = 3
) (
    input  logic                 clk,
    input  logic                 highRst,
    input  logic                 sInstrValid,
    output logic                 sInstrReady,
    input  logic [2:0]           sOpAlu,
    input  logic [SELECTION-1:0] sSelA,
    input  logic [SELECTION-1:0] sSelB,
    input  logic [SELECTION-1:0] sSelC,
    input  logic                 sImmSel,
    input  logic [DATAWIDTH-1:0] sImm,
    output logic                 sDone,
    output logic                 sOverflow,
    output logic                 sCarry,
    output logic                 sNegative,
    output logic                 sZero,
    input  logic [SELECTION-1:0] sDbgSel,
    output logic [DATAWIDTH-1:0] sDbgData
);

    localparam int unsigned CNTWIDTH = $clog2(DATAWIDTH + 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpShr = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StMul, StWb} stateT;

    stateT                  state;
    logic [DATAWIDTH-1:0]   regFile [REGCOUNT];

    // Captured instruction fields
    logic [2:0]             opReg;
    logic [SELECTION-1:0]   selAReg;
    logic [SELECTION-1:0]   selBReg;
    logic [SELECTION-1:0]   selCReg;
    logic                   immSelReg;
    logic [DATAWIDTH-1:0]   immReg;

    // Result and flags waiting for the WB edge
    logic [DATAWIDTH-1:0]   resReg;
    logic                   pendC;
    logic                   pendV;
    logic                   doneReg;

    // Shift-add multiplier state
    logic [2*DATAWIDTH-1:0] mcand;
    logic [DATAWIDTH-1:0]   mplier;
    logic [2*DATAWIDTH-1:0] acc;
    logic [CNTWIDTH-1:0]    mulCount;

    logic [DATAWIDTH-1:0]   busA;
    logic [DATAWIDTH-1:0]   busB;
    logic [DATAWIDTH-1:0]   aluRes;
    logic                   aluC;
    logic                   aluV;
    logic [DATAWIDTH:0]     wideSum;
    logic [DATAWIDTH:0]     wideDiff;
    logic [2*DATAWIDTH-1:0] accNext;

    // Entry 0 is never written, so it always reads back as zero.
    assign busA     = regFile[selAReg];
    assign busB     = immSelReg ? immReg : regFile[selBReg];
    assign sDbgData = regFile[sDbgSel];

    assign sInstrReady = (state == StIdle) && !highRst;
    assign sDone       = doneReg;

    assign wideSum  = {1'b0, busA} + {1'b0, busB};
    assign wideDiff = {1'b0, busA} - {1'b0, busB};
    assign accNext  = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        aluRes = '0;
        aluC   = 1'b0;
        aluV   = 1'b0;
        unique case (opReg)
            OpAdd: begin
                aluRes = wideSum[DATAWIDTH-1:0];
                aluC   = wideSum[DATAWIDTH];
                // Same-sign operands producing an opposite-sign result
                aluV   = (busA[DATAWIDTH-1] == busB[DATAWIDTH-1]) &&
                         (wideSum[DATAWIDTH-1] != busA[DATAWIDTH-1]);
            end
            OpSub: begin
                aluRes = wideDiff[DATAWIDTH-1:0];
                aluC   = wideDiff[DATAWIDTH];  // borrow
                aluV   = (busA[DATAWIDTH-1] != busB[DATAWIDTH-1]) &&
                         (wideDiff[DATAWIDTH-1] != busA[DATAWIDTH-1]);
            end
            OpAnd: aluRes = busA & busB;
            OpOr:  aluRes = busA | busB;
            OpXor: aluRes = busA ^ busB;
            OpShl: begin
                aluRes = busA << 1;
                aluC   = busA[DATAWIDTH-1];
            end
            OpShr: begin
                aluRes = busA >> 1;
                aluC   = busA[0];
            end
            OpMul: aluRes = '0;  // handled by the iterative multiplier
            default: aluRes = '0;
        endcase
    end

    always_ff @(posedge clk or posedge highRst) begin
        if (highRst) begin
            state     <= StIdle;
            for (int i = 0; i < int'(REGCOUNT); i++) begin
                regFile[i] <= '0;
            end
            opReg     <= '0;
            selAReg   <= '0;
            selBReg   <= '0;
            selCReg   <= '0;
            immSelReg <= 1'b0;
            immReg    <= '0;
            resReg    <= '0;
            pendC     <= 1'b0;
            pendV     <= 1'b0;
            doneReg   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            mulCount  <= '0;
            sOverflow <= 1'b0;
            sCarry    <= 1'b0;
            sNegative <= 1'b0;
            sZero     <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (sInstrValid) begin
                        opReg     <= sOpAlu;
                        selAReg   <= sSelA;
                        selBReg   <= sSelB;
                        selCReg   <= sSelC;
                        immSelReg <= sImmSel;
                        immReg    <= sImm;
                        state     <= StExec;
                    end
                end
                StExec: begin
                    if (opReg == OpMul) begin
                        mcand    <= {{DATAWIDTH{1'b0}}, busA};
                        mplier   <= busB;
                        acc      <= '0;
                        mulCount <= CNTWIDTH'(DATAWIDTH);
                        state    <= StMul;
                    end else begin
                        resReg  <= aluRes;
                        pendC   <= aluC;
                        pendV   <= aluV;
                        doneReg <= 1'b1;
                        state   <= StWb;
                    end
                end
                StMul: begin
                    acc      <= accNext;
                    mcand    <= mcand << 1;
                    mplier   <= mplier >> 1;
                    mulCount <= mulCount - CNTWIDTH'(1);
                    // Last iteration: take the product including this step's addend
                    if (mulCount == CNTWIDTH'(1)) begin
                        resReg  <= accNext[DATAWIDTH-1:0];
                        pendC   <= |accNext[2*DATAWIDTH-1:DATAWIDTH];
                        pendV   <= 1'b0;
                        doneReg <= 1'b1;
                        state   <= StWb;
                    end
                end
                StWb: begin
                    if (selCReg != '0) begin
                        regFile[selCReg] <= resReg;
                    end
                    sZero     <= (resReg == '0);
                    sNegative <= resReg[DATAWIDTH-1];
                    sCarry    <= pendC;
                    sOverflow <= pendV;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_core.sv
module tb_datapath_core;

    localparam int DW = 8;

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpShl = 3'b101;
    localparam logic [2:0] OpShr = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    logic          clk;
    logic          highRst;
    logic          sInstrValid;
    logic          sInstrReady;
    logic [2:0]    sOpAlu;
    logic [2:0]    sSelA;
    logic [2:0]    sSelB;
    logic [2:0]    sSelC;
    logic          sImmSel;
    logic [DW-1:0] sImm;
    logic          sDone;
    logic          sOverflow;
    logic          sCarry;
    logic          sNegative;
    logic          sZero;
    logic [2:0]    sDbgSel;
    logic [DW-1:0] sDbgData;

    datapath_core #(
        .DATAWIDTH(8),
        .REGCOUNT (8),
        .SELECTION(3)
    ) dut (
        .clk        (clk),
        .highRst    (highRst),
        .sInstrValid(sInstrValid),
        .sInstrReady(sInstrReady),
        .sOpAlu     (sOpAlu),
        .sSelA      (sSelA),
        .sSelB      (sSelB),
        .sSelC      (sSelC),
        .sImmSel    (sImmSel),
        .sImm       (sImm),
        .sDone      (sDone),
        .sOverflow  (sOverflow),
        .sCarry     (sCarry),
        .sNegative  (sNegative),
        .sZero      (sZero),
        .sDbgSel    (sDbgSel),
        .sDbgData   (sDbgData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags packed as {V, C, N, Z}
    typedef struct {
        logic [2:0]    op;
        logic [2:0]    selA;
        logic [2:0]    selB;
        logic [2:0]    selC;
        logic          immSel;
        logic [DW-1:0] imm;
        logic [DW-1:0] expRes;
        logic [3:0]    expFlags;
    } vecT;

    vecT        vecs[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] prevFlags = 4'b0000;

    function automatic vecT mk(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] c, input logic immSel, input logic [7:0] imm,
                               input logic [7:0] res, input logic [3:0] flags);
        vecT v;
        v.op = op; v.selA = a; v.selB = b; v.selC = c; v.immSel = immSel; v.imm = imm;
        v.expRes = res; v.expFlags = flags;
        return v;
    endfunction

    function automatic logic [3:0] flagsNow();
        return {sOverflow, sCarry, sNegative, sZero};
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic immSel, input logic [7:0] imm);
        sOpAlu = op; sSelA = a; sSelB = b; sSelC = c; sImmSel = immSel; sImm = imm;
    endtask

    // Issue one instruction, check latency, ready, flag hold and the committed result.
    task automatic runVec(input string tag, input vecT v);
        int cycles;
        int expLat;
        logic got;
        expLat = (v.op == OpMul) ? DW + 2 : 2;
        @(negedge clk);
        checkVal({tag, " ready before issue"}, 32'(sInstrReady), 32'd1);
        drive(v.op, v.selA, v.selB, v.selC, v.immSel, v.imm);
        sDbgSel = v.selC;
        sInstrValid = 1'b1;
        @(posedge clk);
        #1 sInstrValid = 1'b0;
        cycles = 0;
        got = 1'b0;
        while (!got && cycles < 40) begin
            @(negedge clk);
            cycles++;
            if (sDone) got = 1'b1;
            else checkVal({tag, " ready while busy"}, 32'(sInstrReady), 32'd0);
        end
        checkVal({tag, " done seen"}, 32'(got), 32'd1);
        if (!got) return;
        checkVal({tag, " done latency"}, 32'(cycles), 32'(expLat));
        checkVal({tag, " ready during wb"}, 32'(sInstrReady), 32'd0);
        checkVal({tag, " flags held before wb"}, 32'(flagsNow()), 32'(prevFlags));
        @(negedge clk);
        checkVal({tag, " done one cycle"}, 32'(sDone), 32'd0);
        checkVal({tag, " ready after wb"}, 32'(sInstrReady), 32'd1);
        checkVal({tag, " flags"}, 32'(flagsNow()), 32'(v.expFlags));
        checkVal({tag, " result"}, 32'(sDbgData), 32'(v.expRes));
        prevFlags = v.expFlags;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        highRst = 1'b1;
        sInstrValid = 1'b0;
        drive(OpAdd, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
        sDbgSel = 3'd0;

        // Vector table: op, selA, selB, selC, immSel, imm, expected result, expected {V,C,N,Z}
        vecs.push_back(mk(OpAdd, 3'd0, 3'd0, 3'd1, 1'b1, 8'h03, 8'h03, 4'b0000));
        vecs.push_back(mk(OpAdd, 3'd0, 3'd0, 3'd2, 1'b1, 8'h02, 8'h02, 4'b0000));
        vecs.push_back(mk(OpAdd, 3'd1, 3'd2, 3'd3, 1'b0, 8'h00, 8'h05, 4'b0000));
        vecs.push_back(mk(OpAdd, 3'd0, 3'd0, 3'd4, 1'b1, 8'h7F, 8'h7F, 4'b0000));
        vecs.push_back(mk(OpAdd, 3'd4, 3'd0, 3'd5, 1'b1, 8'h01, 8'h80, 4'b1010));
        vecs.push_back(mk(OpAdd, 3'd0, 3'd0, 3'd6, 1'b1, 8'hFF, 8'hFF, 4'b0010));
        vecs.push_back(mk(OpAdd, 3'd6, 3'd0, 3'd7, 1'b1, 8'h01, 8'h00, 4'b0101));
        vecs.push_back(mk(OpSub, 3'd2, 3'd0, 3'd1, 1'b1, 8'h03, 8'hFF, 4'b0110));
        vecs.push_back(mk(OpSub, 3'd5, 3'd0, 3'd1, 1'b1, 8'h01, 8'h7F, 4'b1000));
        vecs.push_back(mk(OpAdd, 3'd0, 3'd0, 3'd2, 1'b1, 8'hAA, 8'hAA, 4'b0010));
        vecs.push_back(mk(OpXor, 3'd2, 3'd2, 3'd3, 1'b0, 8'h00, 8'h00, 4'b0001));
        vecs.push_back(mk(OpAnd, 3'd2, 3'd0, 3'd3, 1'b1, 8'h0F, 8'h0A, 4'b0000));
        vecs.push_back(mk(OpOr,  3'd2, 3'd0, 3'd3, 1'b1, 8'h0F, 8'hAF, 4'b0010));
        vecs.push_back(mk(OpAdd, 3'd0, 3'd0, 3'd4, 1'b1, 8'h81, 8'h81, 4'b0010));
        vecs.push_back(mk(OpShl, 3'd4, 3'd0, 3'd4, 1'b0, 8'h00, 8'h02, 4'b0100));
        vecs.push_back(mk(OpAdd, 3'd0, 3'd0, 3'd5, 1'b1, 8'h01, 8'h01, 4'b0000));
        vecs.push_back(mk(OpShr, 3'd5, 3'd0, 3'd5, 1'b0, 8'h00, 8'h00, 4'b0101));
        vecs.push_back(mk(OpAdd, 3'd0, 3'd0, 3'd1, 1'b1, 8'h0D, 8'h0D, 4'b0000));
        vecs.push_back(mk(OpMul, 3'd1, 3'd0, 3'd6, 1'b1, 8'h0B, 8'h8F, 4'b0010));
        vecs.push_back(mk(OpAdd, 3'd0, 3'd0, 3'd2, 1'b1, 8'h14, 8'h14, 4'b0000));
        vecs.push_back(mk(OpMul, 3'd2, 3'd2, 3'd7, 1'b0, 8'h00, 8'h90, 4'b0110));
        vecs.push_back(mk(OpAdd, 3'd0, 3'd0, 3'd0, 1'b1, 8'h05, 8'h00, 4'b0000));
        vecs.push_back(mk(OpMul, 3'd0, 3'd0, 3'd3, 1'b1, 8'h55, 8'h00, 4'b0001));
        vecs.push_back(mk(OpAdd, 3'd0, 3'd0, 3'd4, 1'b1, 8'hFF, 8'hFF, 4'b0010));
        vecs.push_back(mk(OpMul, 3'd4, 3'd4, 3'd4, 1'b0, 8'h00, 8'h01, 4'b0100));

        // Reset state
        repeat (2) @(negedge clk);
        checkVal("reset ready low", 32'(sInstrReady), 32'd0);
        checkVal("reset done low", 32'(sDone), 32'd0);
        highRst = 1'b0;
        #1;
        checkVal("ready after release", 32'(sInstrReady), 32'd1);
        checkVal("reset flags", 32'(flagsNow()), 32'd0);
        for (int r = 0; r < 8; r++) begin
            sDbgSel = 3'(r);
            #1 checkVal($sformatf("reset reg%0d", r), 32'(sDbgData), 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            runVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Busy handshake: a second instruction held during EXEC/WB is taken at the next IDLE edge
        @(negedge clk);
        drive(OpAdd, 3'd0, 3'd0, 3'd1, 1'b1, 8'h09);
        sInstrValid = 1'b1;
        @(posedge clk);
        #1 drive(OpAdd, 3'd1, 3'd0, 3'd2, 1'b1, 8'h01);
        @(negedge clk);
        checkVal("busy exec ready", 32'(sInstrReady), 32'd0);
        @(negedge clk);
        checkVal("busy wb done", 32'(sDone), 32'd1);
        checkVal("busy wb ready", 32'(sInstrReady), 32'd0);
        @(negedge clk);
        checkVal("busy idle ready", 32'(sInstrReady), 32'd1);
        sDbgSel = 3'd1;
        #1 checkVal("busy first result", 32'(sDbgData), 32'h09);
        @(posedge clk);
        #1 sInstrValid = 1'b0;
        @(negedge clk);
        checkVal("busy second exec", 32'(sDone), 32'd0);
        @(negedge clk);
        checkVal("busy second done", 32'(sDone), 32'd1);
        @(negedge clk);
        sDbgSel = 3'd2;
        #1 checkVal("busy second result", 32'(sDbgData), 32'h0A);
        prevFlags = 4'b0000;

        // Reset during the 4th MUL cycle
        runVec("pre-mul", mk(OpAdd, 3'd0, 3'd0, 3'd1, 1'b1, 8'hFF, 8'hFF, 4'b0010));
        @(negedge clk);
        drive(OpMul, 3'd1, 3'd0, 3'd3, 1'b1, 8'h02);
        sInstrValid = 1'b1;
        @(posedge clk);
        #1 sInstrValid = 1'b0;
        repeat (4) @(posedge clk);
        #2 highRst = 1'b1;
        #1;
        checkVal("midmul ready", 32'(sInstrReady), 32'd0);
        checkVal("midmul done", 32'(sDone), 32'd0);
        checkVal("midmul flags", 32'(flagsNow()), 32'd0);
        sDbgSel = 3'd1;
        #1 checkVal("midmul r1 cleared", 32'(sDbgData), 32'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkVal("midmul no done", 32'(sDone), 32'd0);
        end
        highRst = 1'b0;
        sDbgSel = 3'd3;
        #1 checkVal("midmul no write", 32'(sDbgData), 32'd0);
        checkVal("midmul ready after release", 32'(sInstrReady), 32'd1);
        prevFlags = 4'b0000;
        runVec("post-reset", mk(OpAdd, 3'd0, 3'd0, 3'd1, 1'b1, 8'h07, 8'h07, 4'b0000));
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkVal("post-reset idle done", 32'(sDone), 32'd0);
        end
        sDbgSel = 3'd3;
        #1 checkVal("post-reset r3 untouched", 32'(sDbgData), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
